// File: rtl/axi_mst_arbiter.sv
// axi_mst_arbiter: 2:1 AXI4 master-port arbiter with ID tagging, W-order FIFO and B/R routing.
// Define AXI_ARB_FIXED_PRIO_EN to make master 0 win every tie instead of round-robin.
module axi_mst_arb_rr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_valid,
  input  logic       i_ready,
  input  logic       i_block,
  output logic       o_sel,
  output logic       o_valid,
  output logic [1:0] o_s_ready
);
  logic r_locked, r_prio, r_gnt;
  logic w_hs;
  always_comb begin
    o_sel     = r_locked ? r_gnt : (&i_valid ? r_prio : i_valid[1]);
    o_valid   = i_valid[o_sel] & ~i_block;
    w_hs      = o_valid & i_ready;
    o_s_ready = {w_hs & o_sel, w_hs & ~o_sel};
  end
  // LOCKED pins the winner so the downstream request stays stable until accepted
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_locked <= 1'b0;
      r_prio   <= 1'b0;
      r_gnt    <= 1'b0;
    end else if (w_hs) begin
      r_locked <= 1'b0;
`ifdef AXI_ARB_FIXED_PRIO_EN
      r_prio   <= 1'b0;
`else
      r_prio   <= ~o_sel;
`endif
    end else if (o_valid & ~r_locked) begin
      r_locked <= 1'b1;
      r_gnt    <= o_sel;
    end
endmodule

module axi_mst_arbiter #(
  parameter int ID_W     = 4,
  parameter int AX_W     = 99,
  parameter int W_W      = 72,
  parameter int RESP_W   = 66,
  parameter int WQ_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          s_aw_valid_i,
  output logic [1:0]          s_aw_ready_o,
  input  logic [2*ID_W-1:0]   s_aw_id_i,
  input  logic [2*AX_W-1:0]   s_aw_pl_i,
  input  logic [1:0]          s_w_valid_i,
  input  logic [1:0]          s_w_last_i,
  output logic [1:0]          s_w_ready_o,
  input  logic [2*W_W-1:0]    s_w_pl_i,
  output logic [1:0]          s_b_valid_o,
  input  logic [1:0]          s_b_ready_i,
  output logic [ID_W-1:0]     s_b_id_o,
  output logic [1:0]          s_b_resp_o,
  input  logic [1:0]          s_ar_valid_i,
  output logic [1:0]          s_ar_ready_o,
  input  logic [2*ID_W-1:0]   s_ar_id_i,
  input  logic [2*AX_W-1:0]   s_ar_pl_i,
  output logic [1:0]          s_r_valid_o,
  input  logic [1:0]          s_r_ready_i,
  output logic [ID_W-1:0]     s_r_id_o,
  output logic [RESP_W-1:0]   s_r_pl_o,
  output logic                s_r_last_o,
  output logic                m_aw_valid_o,
  input  logic                m_aw_ready_i,
  output logic [ID_W:0]       m_aw_id_o,
  output logic [AX_W-1:0]     m_aw_pl_o,
  output logic                m_w_valid_o,
  input  logic                m_w_ready_i,
  output logic [W_W-1:0]      m_w_pl_o,
  output logic                m_w_last_o,
  input  logic                m_b_valid_i,
  output logic                m_b_ready_o,
  input  logic [ID_W:0]       m_b_id_i,
  input  logic [1:0]          m_b_resp_i,
  output logic                m_ar_valid_o,
  input  logic                m_ar_ready_i,
  output logic [ID_W:0]       m_ar_id_o,
  output logic [AX_W-1:0]     m_ar_pl_o,
  input  logic                m_r_valid_i,
  output logic                m_r_ready_o,
  input  logic [ID_W:0]       m_r_id_i,
  input  logic [RESP_W-1:0]   m_r_pl_i,
  input  logic                m_r_last_i
);
  localparam int QA_W = $clog2(WQ_DEPTH);
  localparam logic [QA_W-1:0] PTR_ONE  = QA_W'(1);
  localparam logic [QA_W:0]   CNT_ONE  = (QA_W+1)'(1);
  localparam logic [QA_W:0]   CNT_FULL = (QA_W+1)'(WQ_DEPTH);
  logic [WQ_DEPTH-1:0] r_wq;
  logic [QA_W-1:0]     r_wr, r_rd;
  logic [QA_W:0]       r_cnt;
  logic w_aw_sel, w_ar_sel, w_wq_full, w_wq_empty, w_push, w_pop, w_head;
  assign w_wq_full  = r_cnt == CNT_FULL;
  assign w_wq_empty = r_cnt == '0;
  axi_mst_arb_rr u_aw (
    .clk_i, .rst_i, .i_valid(s_aw_valid_i), .i_ready(m_aw_ready_i), .i_block(w_wq_full),
    .o_sel(w_aw_sel), .o_valid(m_aw_valid_o), .o_s_ready(s_aw_ready_o)
  );
  axi_mst_arb_rr u_ar (
    .clk_i, .rst_i, .i_valid(s_ar_valid_i), .i_ready(m_ar_ready_i), .i_block(1'b0),
    .o_sel(w_ar_sel), .o_valid(m_ar_valid_o), .o_s_ready(s_ar_ready_o)
  );
  always_comb begin
    m_aw_id_o   = {w_aw_sel, w_aw_sel ? s_aw_id_i[2*ID_W-1:ID_W] : s_aw_id_i[ID_W-1:0]};
    m_aw_pl_o   = w_aw_sel ? s_aw_pl_i[2*AX_W-1:AX_W] : s_aw_pl_i[AX_W-1:0];
    m_ar_id_o   = {w_ar_sel, w_ar_sel ? s_ar_id_i[2*ID_W-1:ID_W] : s_ar_id_i[ID_W-1:0]};
    m_ar_pl_o   = w_ar_sel ? s_ar_pl_i[2*AX_W-1:AX_W] : s_ar_pl_i[AX_W-1:0];
    w_head      = r_wq[r_rd];
    m_w_valid_o = ~w_wq_empty & s_w_valid_i[w_head];
    m_w_last_o  = ~w_wq_empty & s_w_last_i[w_head];
    m_w_pl_o    = w_head ? s_w_pl_i[2*W_W-1:W_W] : s_w_pl_i[W_W-1:0];
    s_w_ready_o = w_wq_empty ? 2'b00 : (w_head ? {m_w_ready_i, 1'b0} : {1'b0, m_w_ready_i});
    w_push      = m_aw_valid_o & m_aw_ready_i;
    w_pop       = m_w_valid_o & m_w_ready_i & m_w_last_o;
    s_b_valid_o = m_b_id_i[ID_W] ? {m_b_valid_i, 1'b0} : {1'b0, m_b_valid_i};
    m_b_ready_o = s_b_ready_i[m_b_id_i[ID_W]];
    s_b_id_o    = m_b_id_i[ID_W-1:0];
    s_b_resp_o  = m_b_resp_i;
    s_r_valid_o = m_r_id_i[ID_W] ? {m_r_valid_i, 1'b0} : {1'b0, m_r_valid_i};
    m_r_ready_o = s_r_ready_i[m_r_id_i[ID_W]];
    s_r_id_o    = m_r_id_i[ID_W-1:0];
    s_r_pl_o    = m_r_pl_i;
    s_r_last_o  = m_r_last_i;
  end
  // W-order FIFO: one entry per accepted AW, popped on the last W beat of that burst
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wq[r_wr] <= w_aw_sel;
        r_wr       <= r_wr + PTR_ONE;
      end
      if (w_pop) r_rd <= r_rd + PTR_ONE;
      r_cnt <= (w_push & ~w_pop) ? r_cnt + CNT_ONE : (w_pop & ~w_push) ? r_cnt - CNT_ONE : r_cnt;
    end
endmodule

// File: tb/tb_axi_mst_arbiter.sv
// tb_axi_mst_arbiter: directed test-plan checks plus randomized traffic against a queue-based model.
module tb_axi_mst_arbiter;
  localparam int ID_W = 4, AX_W = 24, W_W = 20, RESP_W = 18, WQ_DEPTH = 4, N = 16;
  logic clk = 1'b0, rst;
  logic [1:0] s_aw_valid_i, s_aw_ready_o, s_w_valid_i, s_w_last_i, s_w_ready_o;
  logic [1:0] s_b_valid_o, s_b_ready_i, s_b_resp_o, s_ar_valid_i, s_ar_ready_o, s_r_valid_o, s_r_ready_i;
  logic [2*ID_W-1:0] s_aw_id_i, s_ar_id_i;
  logic [2*AX_W-1:0] s_aw_pl_i, s_ar_pl_i;
  logic [2*W_W-1:0] s_w_pl_i;
  logic [ID_W-1:0] s_b_id_o, s_r_id_o;
  logic [RESP_W-1:0] s_r_pl_o, m_r_pl_i;
  logic s_r_last_o, m_aw_valid_o, m_aw_ready_i, m_w_valid_o, m_w_ready_i, m_w_last_o;
  logic m_b_valid_i, m_b_ready_o, m_ar_valid_o, m_ar_ready_i, m_r_valid_i, m_r_ready_o, m_r_last_i;
  logic [ID_W:0] m_aw_id_o, m_b_id_i, m_ar_id_o, m_r_id_i;
  logic [AX_W-1:0] m_aw_pl_o, m_ar_pl_o;
  logic [W_W-1:0] m_w_pl_o;
  logic [1:0] m_b_resp_i;

  logic ar_v[2], aw_v[2], w_v[2], w_last[2];
  logic [ID_W-1:0] ar_id[2], aw_id[2];
  logic [AX_W-1:0] ar_pl[2], aw_pl[2];
  logic [W_W-1:0] w_pl[2];
  assign s_ar_valid_i = {ar_v[1], ar_v[0]};
  assign s_ar_id_i    = {ar_id[1], ar_id[0]};
  assign s_ar_pl_i    = {ar_pl[1], ar_pl[0]};
  assign s_aw_valid_i = {aw_v[1], aw_v[0]};
  assign s_aw_id_i    = {aw_id[1], aw_id[0]};
  assign s_aw_pl_i    = {aw_pl[1], aw_pl[0]};
  assign s_w_valid_i  = {w_v[1], w_v[0]};
  assign s_w_last_i   = {w_last[1], w_last[0]};
  assign s_w_pl_i     = {w_pl[1], w_pl[0]};

  axi_mst_arbiter #(.ID_W(ID_W), .AX_W(AX_W), .W_W(W_W), .RESP_W(RESP_W), .WQ_DEPTH(WQ_DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o), .s_aw_id_i(s_aw_id_i), .s_aw_pl_i(s_aw_pl_i),
    .s_w_valid_i(s_w_valid_i), .s_w_last_i(s_w_last_i), .s_w_ready_o(s_w_ready_o), .s_w_pl_i(s_w_pl_i),
    .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i), .s_b_id_o(s_b_id_o), .s_b_resp_o(s_b_resp_o),
    .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o), .s_ar_id_i(s_ar_id_i), .s_ar_pl_i(s_ar_pl_i),
    .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i), .s_r_id_o(s_r_id_o), .s_r_pl_o(s_r_pl_o),
    .s_r_last_o(s_r_last_o),
    .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i), .m_aw_id_o(m_aw_id_o), .m_aw_pl_o(m_aw_pl_o),
    .m_w_valid_o(m_w_valid_o), .m_w_ready_i(m_w_ready_i), .m_w_pl_o(m_w_pl_o), .m_w_last_o(m_w_last_o),
    .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o), .m_b_id_i(m_b_id_i), .m_b_resp_i(m_b_resp_i),
    .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i), .m_ar_id_o(m_ar_id_o), .m_ar_pl_o(m_ar_pl_o),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o), .m_r_id_i(m_r_id_i), .m_r_pl_i(m_r_pl_i),
    .m_r_last_i(m_r_last_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic sb_on = 1'b0;
  logic [ID_W+AX_W-1:0] q_ar[2][$], q_aw[2][$];
  int q_awlen[2][$];
  logic [W_W:0] q_wsrc[2][$], q_wdrv[2][$], w_exp[$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: event not expected by model", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      ar_v[m] = 0; aw_v[m] = 0; w_v[m] = 0; w_last[m] = 0;
      ar_id[m] = '0; aw_id[m] = '0; ar_pl[m] = '0; aw_pl[m] = '0; w_pl[m] = '0;
    end
    m_aw_ready_i = 0; m_ar_ready_i = 0; m_w_ready_i = 0;
    m_b_valid_i = 0; m_b_id_i = '0; m_b_resp_i = '0; s_b_ready_i = '0;
    m_r_valid_i = 0; m_r_id_i = '0; m_r_pl_i = '0; m_r_last_i = 0; s_r_ready_i = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  // Scoreboard monitor: each master's oldest outstanding request must be what appears downstream
  always @(negedge clk) begin
    if (sb_on) begin
      int k, n;
      logic kr, kb;
      if (m_ar_valid_o) begin
        k = int'(m_ar_id_o[ID_W]);
        if (q_ar[k].size() == 0) fail("ar_extra");
        else begin
          check("ar_req", {m_ar_id_o[ID_W-1:0], m_ar_pl_o}, q_ar[k][0]);
          if (m_ar_ready_i) void'(q_ar[k].pop_front());
        end
      end
      if (m_aw_valid_o) begin
        k = int'(m_aw_id_o[ID_W]);
        if (q_aw[k].size() == 0) fail("aw_extra");
        else begin
          check("aw_req", {m_aw_id_o[ID_W-1:0], m_aw_pl_o}, q_aw[k][0]);
          if (m_aw_ready_i) begin
            void'(q_aw[k].pop_front());
            n = q_awlen[k].pop_front();
            for (int b = 0; b <= n; b++) w_exp.push_back(q_wsrc[k].pop_front());
          end
        end
      end
      if (m_w_valid_o) begin
        if (w_exp.size() == 0) fail("w_extra");
        else begin
          check("w_beat", {m_w_last_o, m_w_pl_o}, w_exp[0]);
          if (m_w_ready_i) void'(w_exp.pop_front());
        end
      end
      kr = m_r_id_i[ID_W];
      kb = m_b_id_i[ID_W];
      check("r_route", {s_r_valid_o, m_r_ready_o, s_r_id_o, s_r_pl_o, s_r_last_o},
            {m_r_valid_i && kr, m_r_valid_i && !kr, s_r_ready_i[kr], m_r_id_i[ID_W-1:0], m_r_pl_i, m_r_last_i});
      check("b_route", {s_b_valid_o, m_b_ready_o, s_b_id_o, s_b_resp_o},
            {m_b_valid_i && kb, m_b_valid_i && !kb, s_b_ready_i[kb], m_b_id_i[ID_W-1:0], m_b_resp_i});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ar_acc[2], aw_acc[2], w_acc[2];
    int ar_n[2], aw_n[2], len, cyc;
    logic [W_W:0] beat;
    do_reset();
    @(negedge clk);
    check("rst_outs", {m_aw_valid_o, m_ar_valid_o, m_w_valid_o, s_aw_ready_o, s_ar_ready_o, s_w_ready_o,
                       s_b_valid_o, s_r_valid_o, m_b_ready_o, m_r_ready_o}, '0);
    tick();
    // round-robin on AR
    ar_id[0] = 4'h1; ar_pl[0] = 24'h0a0a0a; ar_id[1] = 4'h2; ar_pl[1] = 24'h0b0b0b;
    ar_v[0] = 1; ar_v[1] = 1; m_ar_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_grant", {m_ar_valid_o, m_ar_id_o}, {1'b1, i[0], i[0] ? 4'h2 : 4'h1});
      tick();
    end
    // stability while downstream is not ready
    ar_v[0] = 0; ar_id[1] = 4'h5; ar_pl[1] = 24'h123456; m_ar_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_hold", {m_ar_valid_o, m_ar_id_o, m_ar_pl_o, s_ar_ready_o}, {1'b1, 1'b1, 4'h5, 24'h123456, 2'b00});
      tick();
      if (i == 0) ar_v[0] = 1;
    end
    m_ar_ready_i = 1;
    @(negedge clk);
    check("lock_hs", {m_ar_valid_o, m_ar_id_o, m_ar_pl_o, s_ar_ready_o}, {1'b1, 1'b1, 4'h5, 24'h123456, 2'b10});
    tick();
    ar_v[1] = 0;
    @(negedge clk);
    check("lock_next", {m_ar_valid_o, m_ar_id_o, m_ar_pl_o, s_ar_ready_o}, {1'b1, 1'b0, 4'h1, 24'h0a0a0a, 2'b01});
    tick();
    ar_v[0] = 0; m_ar_ready_i = 0;
    // W ordering follows AW grant order
    aw_id[0] = 4'h3; aw_pl[0] = 24'h000001; aw_id[1] = 4'h4; aw_pl[1] = 24'h000000;
    aw_v[0] = 1; aw_v[1] = 1; m_aw_ready_i = 1;
    @(negedge clk);
    check("aw_first", {m_aw_valid_o, m_aw_id_o, s_aw_ready_o}, {1'b1, 1'b0, 4'h3, 2'b01});
    tick();
    aw_v[0] = 0;
    @(negedge clk);
    check("aw_second", {m_aw_valid_o, m_aw_id_o, s_aw_ready_o}, {1'b1, 1'b1, 4'h4, 2'b10});
    tick();
    aw_v[1] = 0; m_aw_ready_i = 0;
    w_v[0] = 1; w_pl[0] = 20'h0d0d0; w_last[0] = 0; w_v[1] = 1; w_pl[1] = 20'h0e0e0; w_last[1] = 1; m_w_ready_i = 1;
    @(negedge clk);
    check("w_beat0", {m_w_valid_o, m_w_last_o, m_w_pl_o, s_w_ready_o}, {1'b1, 1'b0, 20'h0d0d0, 2'b01});
    tick();
    w_pl[0] = 20'h0d0d1; w_last[0] = 1;
    @(negedge clk);
    check("w_beat1", {m_w_valid_o, m_w_last_o, m_w_pl_o, s_w_ready_o}, {1'b1, 1'b1, 20'h0d0d1, 2'b01});
    tick();
    w_v[0] = 0;
    @(negedge clk);
    check("w_beat2", {m_w_valid_o, m_w_last_o, m_w_pl_o, s_w_ready_o}, {1'b1, 1'b1, 20'h0e0e0, 2'b10});
    tick();
    w_v[1] = 0; m_w_ready_i = 0;
    // W-order FIFO full stalls the next AW
    aw_v[0] = 1; aw_id[0] = 4'h6; m_aw_ready_i = 1;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      @(negedge clk);
      check("wq_fill", {m_aw_valid_o, s_aw_ready_o}, {1'b1, 2'b01});
      tick();
    end
    @(negedge clk);
    check("wq_full", {m_aw_valid_o, s_aw_ready_o}, {1'b0, 2'b00});
    tick();
    w_v[0] = 1; w_last[0] = 1; w_pl[0] = 20'h00777; m_w_ready_i = 1;
    @(negedge clk);
    check("wq_full_w", {m_aw_valid_o, s_aw_ready_o, m_w_valid_o, s_w_ready_o}, {1'b0, 2'b00, 1'b1, 2'b01});
    tick();
    w_v[0] = 0;
    @(negedge clk);
    check("wq_resume", {m_aw_valid_o, s_aw_ready_o}, {1'b1, 2'b01});
    tick();
    aw_v[0] = 0; m_aw_ready_i = 0; m_w_ready_i = 0;
    // response routing
    m_r_id_i = 5'b1_0011; m_r_valid_i = 1; s_r_ready_i = 2'b10;
    #1;
    check("r_dir", {s_r_valid_o, s_r_id_o, m_r_ready_o}, {2'b10, 4'h3, 1'b1});
    m_b_id_i = 5'b0_0111; m_b_valid_i = 1; s_b_ready_i = 2'b10;
    #1;
    check("b_dir", {s_b_valid_o, s_b_id_o, m_b_ready_o}, {2'b01, 4'h7, 1'b0});
    // reset while AR is locked and the FIFO holds two entries
    do_reset();
    aw_v[1] = 1; m_aw_ready_i = 1;
    tick();
    tick();
    aw_v[1] = 0; m_aw_ready_i = 0; ar_v[1] = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    ar_v[0] = 1; ar_v[1] = 1; w_v[0] = 1; w_v[1] = 1; w_last[0] = 1; w_last[1] = 1; m_w_ready_i = 1;
    @(negedge clk);
    check("rst_mid", {m_ar_valid_o, m_ar_id_o[ID_W], m_aw_valid_o, s_aw_ready_o, s_ar_ready_o, m_w_valid_o, s_w_ready_o},
          {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00});
    tick();
    // randomized traffic
    do_reset();
    sb_on = 1;
    ar_n = '{0, 0}; aw_n = '{0, 0}; cyc = 0;
    while (cyc < 4000 && !(ar_n[0] == N && ar_n[1] == N && aw_n[0] == N && aw_n[1] == N &&
           !ar_v[0] && !ar_v[1] && !aw_v[0] && !aw_v[1] && !w_v[0] && !w_v[1] &&
           q_wdrv[0].size() == 0 && q_wdrv[1].size() == 0)) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        ar_acc[m] = ar_v[m] & s_ar_ready_o[m];
        aw_acc[m] = aw_v[m] & s_aw_ready_o[m];
        w_acc[m]  = w_v[m] & s_w_ready_o[m];
      end
      tick();
      cyc++;
      for (int m = 0; m < 2; m++) begin
        if (ar_acc[m]) ar_v[m] = 0;
        if (!ar_v[m] && ar_n[m] < N && $urandom_range(1, 0) == 1) begin
          ar_id[m] = ID_W'($urandom); ar_pl[m] = AX_W'($urandom); ar_v[m] = 1; ar_n[m]++;
          q_ar[m].push_back({ar_id[m], ar_pl[m]});
        end
        if (aw_acc[m]) aw_v[m] = 0;
        if (!aw_v[m] && aw_n[m] < N && $urandom_range(1, 0) == 1) begin
          aw_id[m] = ID_W'($urandom); aw_pl[m] = AX_W'($urandom); aw_v[m] = 1; aw_n[m]++;
          q_aw[m].push_back({aw_id[m], aw_pl[m]});
          len = int'($urandom_range(3, 0));
          q_awlen[m].push_back(len);
          for (int b = 0; b <= len; b++) begin
            beat = {b == len, W_W'($urandom)};
            q_wsrc[m].push_back(beat);
            q_wdrv[m].push_back(beat);
          end
        end
        if (w_acc[m]) w_v[m] = 0;
        if (!w_v[m] && q_wdrv[m].size() > 0 && $urandom_range(1, 0) == 1) begin
          {w_last[m], w_pl[m]} = q_wdrv[m].pop_front();
          w_v[m] = 1;
        end
      end
      m_ar_ready_i = $urandom_range(3, 0) != 0;
      m_aw_ready_i = $urandom_range(3, 0) != 0;
      m_w_ready_i  = $urandom_range(3, 0) != 0;
      m_r_valid_i = 1'($urandom); m_r_id_i = (ID_W+1)'($urandom); m_r_pl_i = RESP_W'($urandom);
      m_r_last_i = 1'($urandom); s_r_ready_i = 2'($urandom);
      m_b_valid_i = 1'($urandom); m_b_id_i = (ID_W+1)'($urandom); m_b_resp_i = 2'($urandom);
      s_b_ready_i = 2'($urandom);
    end
    if (cyc >= 4000) fail("random_timeout");
    repeat (3) tick();
    check("sb_empty", w_exp.size() + q_ar[0].size() + q_ar[1].size() + q_aw[0].size() + q_aw[1].size(), '0);
    check("sb_count", ar_n[0] + ar_n[1] + aw_n[0] + aw_n[1], 4 * N);
    sb_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_mst_arbiter.md
# axi_mst_arbiter

Two-to-one AXI4 master-port arbiter that lets two requesters share the single AXI master interface of the `ariane` core complex. Typical requesters are the core's memory port (master 0) and a debug or DMA requester (master 1). AW and AR are arbitrated independently. The winner's index is prepended to the transaction ID, and B/R responses are routed back by that ID bit. W beats follow the AW grant order through an internal order FIFO.

## Interface
Parameters:
- `ID_W`, default 4: upstream ID width; downstream ID width is `ID_W+1`.
- `AX_W`, default 64+8+3+2+1+4+3+4+4+6 = 99: opaque AW/AR payload (addr, len, size, burst, lock, cache, prot, qos, region, atop), passed through unchanged.
- `W_W`, default 64+8: opaque W payload (data, strb).
- `RESP_W`, default 2+64: opaque R payload (resp, data). The B payload is always 2 bits.
- `WQ_DEPTH`, default 4: depth of the W-order FIFO; a power of 2, ≥ 2.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `s_aw_valid_i` / `s_aw_ready_o`  in/out  2 / 2  per-master AW handshake; bit n is master n.
- `s_aw_id_i`  in  2*ID_W  per-master AW ID.
- `s_aw_pl_i`  in  2*AX_W  per-master AW payload.
- `s_w_valid_i`, `s_w_last_i`  in  2 each; `s_w_ready_o`  out  2; `s_w_pl_i`  in  2*W_W.
- `s_b_valid_o`  out  2; `s_b_ready_i`  in  2; `s_b_id_o`  out  ID_W; `s_b_resp_o`  out  2.
- `s_ar_valid_i` / `s_ar_ready_o`  in/out  2 / 2; `s_ar_id_i`  in  2*ID_W; `s_ar_pl_i`  in  2*AX_W.
- `s_r_valid_o`  out  2; `s_r_ready_i`  in  2; `s_r_id_o`  out  ID_W; `s_r_pl_o`  out  RESP_W; `s_r_last_o`  out  1.
- `m_aw_valid_o` out 1; `m_aw_ready_i` in 1; `m_aw_id_o` out ID_W+1; `m_aw_pl_o` out AX_W.
- `m_w_valid_o` out 1; `m_w_ready_i` in 1; `m_w_pl_o` out W_W; `m_w_last_o` out 1.
- `m_b_valid_i` in 1; `m_b_ready_o` out 1; `m_b_id_i` in ID_W+1; `m_b_resp_i` in 2.
- `m_ar_valid_o` out 1; `m_ar_ready_i` in 1; `m_ar_id_o` out ID_W+1; `m_ar_pl_o` out AX_W.
- `m_r_valid_i` in 1; `m_r_ready_o` out 1; `m_r_id_i` in ID_W+1; `m_r_pl_i` in RESP_W; `m_r_last_i` in 1.

## Operation
- **AW and AR arbiters.** Two identical arbiters, each with a state bit IDLE/LOCKED, a round-robin pointer `prio` (the master favoured on a tie) and a registered winner `gnt`.
- **IDLE.** If exactly one master is valid, it wins. If both are valid, master `prio` wins.
  - The winner's request is driven combinationally on `m_ax*`, with `m_ax_id_o = {winner, s_ax_id}`.
  - If `m_ax_ready_i` is high, the handshake completes this cycle and `prio` becomes `~winner`.
  - If `m_ax_ready_i` is low, the state moves to LOCKED and `gnt` is set to the winner.
- **LOCKED.** Only master `gnt` is driven. The state returns to IDLE on handshake, and `prio` becomes `~gnt`. Together with IDLE, this keeps `m_ax*` stable while valid is high without ready.
- **AW handshake gating.**
  - `s_aw_ready_o[n] = m_aw_ready_i & selected(n) & ~wq_full`.
  - `m_aw_valid_o` is forced low while `wq_full`.
  - On each AW handshake, the winner index is pushed into the W-order FIFO.
- **W routing.**
  - If the FIFO is empty, `m_w_valid_o` is 0 and `s_w_ready_o` is 0.
  - Otherwise the FIFO head `h` selects the path: `m_w_* = s_w_*[h]`, `s_w_ready_o[h] = m_w_ready_i`, and the other ready bit is 0.
  - The FIFO pops on a W handshake with last set.
  - Push and pop in the same cycle are allowed; the count is unchanged.
- **B/R routing.**
  - Index `k = m_x_id_i[ID_W]`; `s_x_valid_o[k] = m_x_valid_i`; `m_x_ready_o = s_x_ready_i[k]`.
  - `s_x_id_o = m_x_id_i[ID_W-1:0]`, shared by both masters.
  - Payload and last are passed through. This path is purely combinational.
- **Reset.**
  - All valid/ready outputs are 0, both arbiters are IDLE with `prio=0`, and the FIFO is empty.
  - Reset mid-burst discards all state; no completion is generated for in-flight transactions.

## Timing
- AW/AR arbitration: 0-cycle latency, combinational from `s_ax_valid_i` to `m_ax_valid_o`.
- W: a beat is accepted no earlier than the cycle after its AW handshake, because the FIFO push becomes visible next cycle. W before AW from the same master stalls.
- B/R: 0-cycle pass-through.
- The AW grant order equals the W order, with up to `WQ_DEPTH` AWs outstanding. The `(WQ_DEPTH+1)`-th AW stalls until one burst's last beat is accepted.
- No combinational path from `m_*_ready_i` to `m_*_valid_o`.

## Configuration
- `AXI_ARB_FIXED_PRIO_EN` defined: `prio` is tied to 0, so master 0 always wins ties. The LOCKED behaviour is unchanged.
- `AXI_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described.

## Test plan
- **Round-robin fairness.** After reset, both masters hold AR valid continuously with `m_ar_ready_i=1`. Required: grants alternate 0,1,0,1, and `m_ar_id_o` MSB alternates.
- **Stability.** Master 1 AR is presented with `m_ar_ready_i=0` for 3 cycles, and master 0 raises valid in cycle 2. Required: `m_ar_id_o`, `m_ar_pl_o` and valid stay on master 1 until the handshake; master 0 is granted next cycle.
- **W ordering.** AW m0 (len=1), then AW m1 (len=0) are accepted, and both masters present W. Required: exactly two beats from m0 appear downstream, then one from m1; m1's `s_w_ready_o` stays 0 during m0's burst.
- **FIFO full.** With `WQ_DEPTH=4`, 4 AWs are accepted with no W. Required: the 5th AW sees `m_aw_valid_o=0` and `s_aw_ready_o=0`. After one W last handshake, the 5th AW is accepted the following cycle.
- **Response routing.** `m_r_id_i=5'b1_0011`, `m_r_valid_i=1`, `s_r_ready_i=2'b10`. Required: `s_r_valid_o=2'b10`, `s_r_id_o=4'h3`, `m_r_ready_o=1`. With B id `5'b0_0111` and `s_b_ready_i=2'b10`: `m_b_ready_o=0`.
- **Reset mid-operation.** `rst_i` is asserted for one cycle with the arbiter LOCKED and the FIFO at count 2. Required: the next cycle shows all outputs at 0 except routed pass-throughs, the FIFO empty, and the first tie granted to master 0.
